// File: rtl/button_cnt_led.sv
// button_cnt_led
//   Shows a mode value to the operator by blinking an LED (value+1) times and
//   then holding a long dark gap. The whole pattern repeats for as long as the
//   block is enabled.
//
//   Optional build macro: LED_RESTART_ON_CHANGE_EN
//     When defined, a change of `value` during a sequence aborts it. The
//     display then restarts from LOAD, so the new value appears at once.
//     When undefined, `value` is sampled only in LOAD.
//
//   Ports
//     clk          system clock
//     rst          synchronous, active-high reset
//     en           display enable; low forces LOAD with the LED dark
//     value        mode value to display (WIDTH bits)
//     led          LED drive, 1 = lit (registered)
//     shown_value  value latched for the current sequence (registered)
//     seq_done     one-cycle pulse on the last gap cycle (registered)
module button_cnt_led #(
  parameter int unsigned WIDTH     = 3,
  parameter int unsigned ON_TICKS  = 4,
  parameter int unsigned OFF_TICKS = 2,
  parameter int unsigned GAP_TICKS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] value,
  output logic             led,
  output logic [WIDTH-1:0] shown_value,
  output logic             seq_done
);

  localparam int unsigned MAX_ONOFF = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int unsigned MAX_TICKS = (MAX_ONOFF > GAP_TICKS) ? MAX_ONOFF : GAP_TICKS;
  localparam int unsigned TW        = $clog2(MAX_TICKS + 1);
  localparam int unsigned BW        = WIDTH + 1;

  localparam logic [TW-1:0] ON_LAST  = TW'(ON_TICKS - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(OFF_TICKS - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_TICKS - 1);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_ON,
    ST_OFF,
    ST_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    tick_q, tick_d;
  logic [BW-1:0]    blinks_q, blinks_d;
  logic [WIDTH-1:0] shown_q, shown_d;
  logic             led_q, led_d;
  logic             done_q, done_d;

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q + 1'b1;
    blinks_d = blinks_q;
    shown_d  = shown_q;

    unique case (state_q)
      ST_LOAD: begin
        shown_d  = value;
        blinks_d = {1'b0, value} + BW'(1);
        tick_d   = '0;
        state_d  = en ? ST_ON : ST_LOAD;
      end
      ST_ON: begin
        if (tick_q == ON_LAST) begin
          tick_d = '0;
          if (blinks_q == BW'(1)) begin
            state_d = ST_GAP;
          end else begin
            blinks_d = blinks_q - BW'(1);
            state_d  = ST_OFF;
          end
        end
      end
      ST_OFF: begin
        if (tick_q == OFF_LAST) begin
          tick_d  = '0;
          state_d = ST_ON;
        end
      end
      ST_GAP: begin
        if (tick_q == GAP_LAST) begin
          tick_d  = '0;
          state_d = ST_LOAD;
        end
      end
      default: begin
        tick_d  = '0;
        state_d = ST_LOAD;
      end
    endcase

    // Disable (and, optionally, a value change) overrides normal sequencing.
    // A LOAD state needs no override: it already resamples and waits for en.
    if (state_q != ST_LOAD) begin
      if (!en) begin
        state_d  = ST_LOAD;
        tick_d   = '0;
        blinks_d = '0;
      end
`ifdef LED_RESTART_ON_CHANGE_EN
      else if (value != shown_q) begin
        state_d = ST_LOAD;
        tick_d  = '0;
      end
`endif
    end

    // Outputs are derived from the next state so they line up with state_q.
    led_d  = (state_d == ST_ON);
    done_d = (state_d == ST_GAP) && (tick_d == GAP_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_LOAD;
      tick_q   <= '0;
      blinks_q <= '0;
      shown_q  <= '0;
      led_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      blinks_q <= blinks_d;
      shown_q  <= shown_d;
      led_q    <= led_d;
      done_q   <= done_d;
    end
  end

  assign led         = led_q;
  assign shown_value = shown_q;
  assign seq_done    = done_q;

endmodule

// File: tb/tb_button_cnt_led.sv
module tb_button_cnt_led;

  localparam int unsigned W     = 3;
  localparam int unsigned ON_T  = 4;
  localparam int unsigned OFF_T = 2;
  localparam int unsigned GAP_T = 8;

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic         en    = 1'b0;
  logic [W-1:0] value = '0;
  logic         led;
  logic         seq_done;
  logic [W-1:0] shown_value;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  button_cnt_led #(
    .WIDTH    (W),
    .ON_TICKS (ON_T),
    .OFF_TICKS(OFF_T),
    .GAP_TICKS(GAP_T)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .value      (value),
    .led        (led),
    .shown_value(shown_value),
    .seq_done   (seq_done)
  );

  // Position-based model: p counts cycles since the LOAD cycle of a sequence.
  function automatic int unsigned period_of(input int unsigned v);
    return (v + 1) * ON_T + v * OFF_T + GAP_T + 1;
  endfunction

  function automatic int unsigned led_of(input int unsigned p, input int unsigned v);
    int unsigned q;
    if (p == 0) return 0;
    q = p - 1;
    if (q >= (v + 1) * ON_T + v * OFF_T) return 0;
    return ((q % (ON_T + OFF_T)) < ON_T) ? 1 : 0;
  endfunction

  int unsigned  m_p = 0;
  int unsigned  m_v = 0;
  logic [W-1:0] m_shown = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_p     <= 0;
      m_v     <= 0;
      m_shown <= '0;
    end else if (!en) begin
      if (m_p == 0) m_shown <= value;
      m_p <= 0;
    end
`ifdef LED_RESTART_ON_CHANGE_EN
    else if (m_p != 0 && value != m_shown) begin
      m_p <= 0;
    end
`endif
    else if (m_p == 0) begin
      m_shown <= value;
      m_v     <= value;
      m_p     <= 1;
    end else begin
      m_p <= (m_p + 1) % period_of(m_v);
    end
  end

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout waiting for DUT at %0t", name, $time);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("led", led, led_of(m_p, m_v));
      chk("shown_value", shown_value, m_shown);
      chk("seq_done", seq_done, (m_p != 0 && m_p == period_of(m_v) - 1) ? 1 : 0);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (seq_done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail("wait_seq_done");
  endtask

  task automatic wait_led(input logic lv);
    for (int i = 0; i < 100; i++) begin
      if (led == lv) return;
      @(negedge clk);
    end
    timeout_fail("wait_led");
  endtask

  // Cycles and lit cycles from one seq_done pulse to the next.
  task automatic measure(output int unsigned per, output int unsigned highs);
    bit ok;
    per   = 0;
    highs = 0;
    wait_done(ok);
    if (!ok) return;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      per++;
      if (led) highs++;
      if (seq_done) return;
    end
    timeout_fail("measure");
  endtask

  initial begin
    int unsigned per, hi, blinks;
    bit ok;
    logic prev;

    rst = 1'b1; en = 1'b0; value = '0;
    step();
    chk_on = 1'b1;
    step();
    chk("reset_led", led, 0);
    chk("reset_shown", shown_value, 0);
    chk("reset_done", seq_done, 0);

    value = 3'd2; en = 1'b1; rst = 1'b0;
    measure(per, hi);
    chk("period_v2", per, 25);
    chk("highs_v2", hi, 12);
    chk("shown_v2", shown_value, 2);

    value = 3'd0;
    measure(per, hi);
    chk("period_v0", per, 13);
    chk("highs_v0", hi, 4);

    value = 3'd7;
    measure(per, hi);
    chk("period_v7", per, 55);
    chk("highs_v7", hi, 32);

    // value changes 2 -> 5 during the second blink
    value = 3'd2;
    wait_done(ok);
    blinks = 0;
    prev   = led;
    ok     = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (led && !prev) blinks++;
      prev = led;
      if (k == 9) value = 3'd5;
      if (seq_done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail("change_seq");
`ifdef LED_RESTART_ON_CHANGE_EN
    chk("change_blinks", blinks, 8);
`else
    chk("change_blinks", blinks, 3);
`endif
    measure(per, hi);
    chk("period_v5", per, 43);
    chk("highs_v5", hi, 24);
    chk("shown_v5", shown_value, 5);

    // en dropped mid-ON, then re-asserted
    value = 3'd3;
    wait_led(1'b1);
    en = 1'b0;
    step();
    chk("en_off_led", led, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("en_hold_led", led, 0);
      chk("en_hold_done", seq_done, 0);
    end
    en = 1'b1;
    chk("en_on_load_led", led, 0);
    step();
    chk("en_on_first_blink", led, 1);
    chk("en_on_shown", shown_value, 3);

    // rst pulsed mid-OFF
    wait_led(1'b0);
    rst = 1'b1; value = 3'd1;
    step();
    chk("rst_mid_led", led, 0);
    chk("rst_mid_shown", shown_value, 0);
    chk("rst_mid_done", seq_done, 0);
    rst = 1'b0;
    step();
    chk("rst_restart_led", led, 1);
    chk("rst_restart_shown", shown_value, 1);
    measure(per, hi);
    chk("period_v1", per, 19);
    chk("highs_v1", hi, 8);

    // rst together with en low
    rst = 1'b1; en = 1'b0;
    step();
    chk("rst_en_led", led, 0);
    chk("rst_en_shown", shown_value, 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_cnt_led.md
Name: button_cnt_led

Overview:
- User-facing output end of the mode-select path: the push-button counter turns presses into a mode value; this block shows that value back to the operator by blinking an LED.
- Blinks the LED (value+1) times, holds a long dark gap, then repeats.
- Sits beside the button counter in the RGB/HSV control logic and drives a board LED directly.

Parameters:
- WIDTH, 3, width of the displayed value.
- ON_TICKS, 4, clk cycles the LED stays lit per blink (>=1).
- OFF_TICKS, 2, dark clk cycles between blinks within one sequence (>=1).
- GAP_TICKS, 8, dark clk cycles after the last blink of a sequence (>=1).

Ports:
- clk  input  1  system clock
- rst  input  1  reset; synchronous, active-high
- en  input  1  display enable
- value  input  WIDTH  mode value to display, e.g. the button counter output
- led  output  1  LED drive, 1 = lit, registered
- shown_value  output  WIDTH  value latched for the current sequence, registered
- seq_done  output  1  one-cycle pulse on the last GAP cycle, registered

Behaviour:
- Reset, synchronous on clk: state=LOAD, led=0, shown_value=0, seq_done=0, tick counter=0, blink counter=0.
- Tick counter width: $clog2 of max(ON_TICKS, OFF_TICKS, GAP_TICKS)+1.
- Blink counter width: WIDTH+1, so value = 2^WIDTH-1 gives 2^WIDTH blinks without overflow.
- FSM states: LOAD, ON, OFF, GAP.
- LOAD (exactly 1 cycle, led=0):
  - shown_value <= value; blinks_left <= value+1; tick counter <= 0.
  - If en=1, go to ON; otherwise stay in LOAD.
- ON (ON_TICKS cycles, led=1): when the tick counter reaches ON_TICKS-1:
  - blinks_left == 1: go to GAP.
  - otherwise: decrement blinks_left and go to OFF.
- OFF (OFF_TICKS cycles, led=0): go to ON after OFF_TICKS cycles.
- GAP (GAP_TICKS cycles, led=0): seq_done=1 on the final GAP cycle only, then go to LOAD.
- Tick counter clears on every state change.
- led is a registered function of state: high exactly while in ON, with no glitch cycle between states.
- Sequence period = (value+1)*ON_TICKS + value*OFF_TICKS + GAP_TICKS + 1 cycles.
- Boundary cases:
  - value=0 gives one blink per sequence.
  - Changes to value during a sequence are ignored until the next LOAD (unless the optional feature is enabled).
- en=0 in any state: next cycle state=LOAD, led=0, seq_done=0, counters cleared.
- en re-asserted: the sequence restarts from LOAD with freshly sampled value.
- rst asserted mid-sequence: next edge returns all outputs to reset values; the LED goes dark immediately.
- rst and en=0 together: reset wins (same outcome).

Optional Feature:
- Macro: LED_RESTART_ON_CHANGE_EN.
- Defined: in ON, OFF or GAP, if value != shown_value:
  - next state = LOAD, led=0 next cycle, no seq_done pulse.
  - The new value is displayed immediately after LOAD, giving the operator instant feedback after a button press.
- Not defined: value is sampled only in LOAD; the current sequence always completes.

Test Plan:
- Defaults, en=1, value=2 after rst → per period: led high 4 cycles, low 2, high 4, low 2, high 4, low 9. Period 25 cycles, seq_done once per period, shown_value=2.
- value=0 → one 4-cycle blink then 9 low, period 13. value=7 → 8 blinks, period 32+14+9=55.
- value changed 2→5 during the 2nd blink, macro undefined → current sequence completes with 3 blinks; the next sequence shows 6 blinks and shown_value=5 from the LOAD cycle onward.
- Same stimulus with LED_RESTART_ON_CHANGE_EN defined → led=0 the cycle after the change, one LOAD cycle, then 6 blinks; no seq_done pulse for the aborted sequence.
- en deasserted mid-ON → led=0 the next cycle and the FSM holds LOAD; en re-asserted → first led high 2 cycles later (LOAD, then ON).
- rst pulsed for 1 cycle mid-OFF → outputs at reset values the cycle after; with en=1 the sequence restarts from LOAD with the current value.
